apple_placer: RTL and testbench

Sequencing controller for apple placement in the snake game. When the collision logic reports the apple was eaten, it issues a one-cycle growth pulse and draws pseudo-random candidate cells. It checks each candidate against the snake-body occupancy store over a request/acknowledge handshake. After a bounded number of rejected draws, it falls back to a deterministic row-major scan. It sits between the collision detector, the snake body store and the VGA renderer, which consumes `apple_x`/`apple_y`/`apple_valid`.

---
 rtl/apple_placer_if.sv | 27 ++
 rtl/apple_placer.sv | 201 ++++++++++++++++++++
 tb/tb_apple_placer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apple_placer_if.sv
// Signal bundle linking apple_placer to the collision detector, snake body store and renderer.
// Occupancy handshake: occ_req rises with occ_x/occ_y stable and stays high until occ_ack is seen
// on a clock edge; occ_hit is meaningful only in that cycle; occ_req then drops for at least one cycle.
interface apple_placer_if;
  logic       eat;
  logic       occ_req;
  logic [5:0] occ_x;
  logic [4:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic       apple_valid;
  logic       grow;
  logic       busy;
  logic       fail;

  modport master (
    input  eat, occ_ack, occ_hit,
    output occ_req, occ_x, occ_y, apple_x, apple_y, apple_valid, grow, busy, fail
  );

  modport slave (
    output eat, occ_ack, occ_hit,
    input  occ_req, occ_x, occ_y, apple_x, apple_y, apple_valid, grow, busy, fail
  );
endinterface

// File: rtl/apple_placer.sv
// Apple placement sequencer: random candidate draws checked against the snake body store,
// falling back to a row-major scan once the try budget is spent.
module apple_placer #(
  parameter int          X_MIN     = 1,
  parameter int          X_MAX     = 38,
  parameter int          Y_MIN     = 1,
  parameter int          Y_MAX     = 28,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          RST_X     = 24,
  parameter int          RST_Y     = 10
) (
  input  logic           clk,
  input  logic           rst,
  apple_placer_if.master pl_bus,
  output logic [2:0]     state_o,
  output logic [15:0]    lfsr_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAW   = 3'd1,
    S_QUERY  = 3'd2,
    S_SCAN   = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  localparam logic [5:0]  XMIN      = 6'(X_MIN);
  localparam logic [5:0]  XMAX      = 6'(X_MAX);
  localparam logic [4:0]  YMIN      = 5'(Y_MIN);
  localparam logic [4:0]  YMAX      = 5'(Y_MAX);
  localparam logic [3:0]  TRIES_LIM = 4'(MAX_TRIES);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  tries_q, tries_d;
  logic        occ_req_q, occ_req_d;
  logic [5:0]  occ_x_q, occ_x_d;
  logic [4:0]  occ_y_q, occ_y_d;
  logic [5:0]  apple_x_q, apple_x_d;
  logic [4:0]  apple_y_q, apple_y_d;
  logic        valid_q, valid_d;
  logic        grow_q, grow_d;
  logic        busy_q, busy_d;
  logic        fail_q, fail_d;

  logic [5:0] raw_x;
  logic [4:0] raw_y;
  logic       in_range;
  logic [3:0] tries_inc;
  logic       ack_seen;

  assign raw_x     = lfsr_q[10:5];
  assign raw_y     = lfsr_q[4:0];
  assign in_range  = (raw_x >= XMIN) && (raw_x <= XMAX) && (raw_y >= YMIN) && (raw_y <= YMAX);
  assign tries_inc = tries_q + 4'd1;
  // An ack only counts while a request is actually outstanding.
  assign ack_seen  = occ_req_q && pl_bus.occ_ack;

  // Galois LFSR, free-running every cycle out of reset.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      tries_q   <= 4'd0;
      occ_req_q <= 1'b0;
      occ_x_q   <= 6'd0;
      occ_y_q   <= 5'd0;
      apple_x_q <= 6'(RST_X);
      apple_y_q <= 5'(RST_Y);
      valid_q   <= 1'b1;
      grow_q    <= 1'b0;
      busy_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      tries_q   <= tries_d;
      occ_req_q <= occ_req_d;
      occ_x_q   <= occ_x_d;
      occ_y_q   <= occ_y_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      valid_q   <= valid_d;
      grow_q    <= grow_d;
      busy_q    <= busy_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    occ_req_d = occ_req_q;
    occ_x_d   = occ_x_q;
    occ_y_d   = occ_y_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    valid_d   = valid_q;
    grow_d    = 1'b0;
    busy_d    = busy_q;
    fail_d    = fail_q;

    unique case (state_q)
      S_IDLE: begin
        // The grow cycle itself is spent in IDLE; apple_valid is already low so eat is masked.
        if (grow_q) begin
          state_d = S_DRAW;
        end else if (pl_bus.eat && valid_q && !fail_q) begin
          grow_d  = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          tries_d = 4'd0;
        end
      end

      S_DRAW: begin
        occ_x_d = raw_x;
        occ_y_d = raw_y;
        if (in_range) begin
          state_d   = S_QUERY;
          occ_req_d = 1'b1;
        end else begin
          tries_d = tries_inc;
          if (tries_inc >= TRIES_LIM) begin
            state_d = S_SCAN;
            occ_x_d = XMIN;
            occ_y_d = YMIN;
          end
        end
      end

      S_QUERY: begin
        if (ack_seen) begin
          occ_req_d = 1'b0;
          if (!pl_bus.occ_hit) begin
            state_d = S_COMMIT;
          end else begin
            tries_d = tries_inc;
            if (tries_inc < TRIES_LIM) begin
              state_d = S_DRAW;
            end else begin
              state_d = S_SCAN;
              occ_x_d = XMIN;
              occ_y_d = YMIN;
            end
          end
        end
      end

      S_SCAN: begin
        // Request low here is the mandatory gap cycle before the next scan query.
        if (!occ_req_q) begin
          occ_req_d = 1'b1;
        end else if (ack_seen) begin
          occ_req_d = 1'b0;
          if (!pl_bus.occ_hit) begin
            state_d = S_COMMIT;
          end else if (occ_x_q == XMAX && occ_y_q == YMAX) begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (occ_x_q == XMAX) begin
            occ_x_d = XMIN;
            occ_y_d = occ_y_q + 5'd1;
          end else begin
            occ_x_d = occ_x_q + 6'd1;
          end
        end
      end

      S_COMMIT: begin
        apple_x_d = occ_x_q;
        apple_y_d = occ_y_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pl_bus.occ_req     = occ_req_q;
  assign pl_bus.occ_x       = occ_x_q;
  assign pl_bus.occ_y       = occ_y_q;
  assign pl_bus.apple_x     = apple_x_q;
  assign pl_bus.apple_y     = apple_y_q;
  assign pl_bus.apple_valid = valid_q;
  assign pl_bus.grow        = grow_q;
  assign pl_bus.busy        = busy_q;
  assign pl_bus.fail        = fail_q;
  assign state_o            = state_q;
  assign lfsr_o             = lfsr_q;

endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer: table of placement scenarios against an emulated body store,
// plus hand-written reset, sticky-fail and late-ack sequences.
module tb_apple_placer;

  localparam int          X_MIN     = 1;
  localparam int          X_MAX     = 38;
  localparam int          Y_MIN     = 1;
  localparam int          Y_MAX     = 28;
  localparam int          MAX_TRIES = 8;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          RST_X     = 24;
  localparam int          RST_Y     = 10;
  localparam int          BUDGET    = 6000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apple_placer_if bus ();
  logic [2:0]  state_o;
  logic [15:0] lfsr_o;

  apple_placer #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .MAX_TRIES(MAX_TRIES), .LFSR_SEED(SEED), .RST_X(RST_X), .RST_Y(RST_Y)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pl_bus  (bus),
    .state_o (state_o),
    .lfsr_o  (lfsr_o)
  );

  // Clock edges since reset release; edge k sees the LFSR value after k shifts.
  int edge_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] v;
    logic        b;
    v = SEED;
    for (int i = 0; i < k; i++) begin
      b = v[0];
      v = v >> 1;
      if (b) v = v ^ 16'hB400;
    end
    return v;
  endfunction

  function automatic bit in_rng(input logic [15:0] v);
    int x;
    int y;
    x = int'(v[10:5]);
    y = int'(v[4:0]);
    return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
  endfunction

  // Emulated body store: 0 empty board, 1 first occ_k queries hit, 2 only (occ_fx,occ_fy) free, 3 full.
  int occ_mode, occ_k, occ_fx, occ_fy;

  function automatic bit occupied(input int idx, input int x, input int y);
    case (occ_mode)
      0:       return 1'b0;
      1:       return idx < occ_k;
      2:       return !(x == occ_fx && y == occ_fy);
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int          pred_x, pred_y, pred_nreq;
  bit          pred_fail;

  task automatic predict(input int draw_edge, input int dly);
    int          e, tries, idx, rx, ry;
    bit          done;
    logic [15:0] v;
    exp_q.delete();
    e = draw_edge; tries = 0; idx = 0; done = 1'b0;
    pred_fail = 1'b0;
    while (!done && tries < MAX_TRIES) begin
      v  = lfsr_at(e);
      rx = int'(v[10:5]);
      ry = int'(v[4:0]);
      if (in_rng(v)) begin
        exp_q.push_back({v[10:5], v[4:0]});
        if (!occupied(idx, rx, ry)) begin
          done = 1'b1; pred_x = rx; pred_y = ry;
        end
        idx++;
        e = e + 2 + dly;
      end else begin
        e = e + 1;
      end
      tries++;
    end
    for (int y = Y_MIN; y <= Y_MAX && !done; y++) begin
      for (int x = X_MIN; x <= X_MAX && !done; x++) begin
        exp_q.push_back({6'(x), 5'(y)});
        if (!occupied(idx, x, y)) begin
          done = 1'b1; pred_x = x; pred_y = y;
        end
        idx++;
      end
    end
    pred_fail = !done;
    pred_nreq = exp_q.size();
  endtask

  // ---------------- driver: body-store responder, called once per negedge ----------------
  int         req_cnt, q_idx, nreq, ack_delay;
  logic [5:0] cur_x;
  logic [4:0] cur_y;

  task automatic respond();
    logic [10:0] e;
    if (bus.occ_req) begin
      if (req_cnt == 0) begin
        cur_x = bus.occ_x;
        cur_y = bus.occ_y;
        nreq++;
        if (exp_q.size() == 0) begin
          check("query_count", nreq, pred_nreq);
        end else begin
          e = exp_q.pop_front();
          check("query_xy", {bus.occ_x, bus.occ_y}, e);
        end
      end else begin
        check("query_stable", {bus.occ_x, bus.occ_y}, {cur_x, cur_y});
      end
      if (req_cnt == ack_delay) begin
        bus.occ_ack = 1'b1;
        bus.occ_hit = occupied(q_idx, int'(cur_x), int'(cur_y));
        q_idx++;
      end else begin
        bus.occ_ack = 1'b0;
        bus.occ_hit = 1'($urandom_range(0, 1));
      end
      req_cnt++;
    end else begin
      bus.occ_ack = 1'b0;
      bus.occ_hit = 1'($urandom_range(0, 1));
      req_cnt     = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_apple_x"}, bus.apple_x, RST_X);
    check({tag, "_apple_y"}, bus.apple_y, RST_Y);
    check({tag, "_valid"},   bus.apple_valid, 1);
    check({tag, "_grow"},    bus.grow, 0);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_fail"},    bus.fail, 0);
    check({tag, "_occ_req"}, bus.occ_req, 0);
    check({tag, "_occ_x"},   bus.occ_x, 0);
    check({tag, "_occ_y"},   bus.occ_y, 0);
    check({tag, "_state"},   state_o, 0);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    string name;
    int    mode;
    int    k;
    int    fx;
    int    fy;
    int    dly;
    bit    hold_eat;
    bit    align;
    bit    exp_fail;
    int    hand_x;
    int    hand_y;
    int    exp_lat;
  } row_t;

  row_t rows[4];

  task automatic run_row(input row_t r);
    int eat_edge, grows, cyc, lat, guard;
    bit done;
    occ_mode = r.mode; occ_k = r.k; occ_fx = r.fx; occ_fy = r.fy;
    ack_delay = r.dly; q_idx = 0; nreq = 0; req_cnt = 0;
    guard = 0;
    // Optionally wait for a moment whose first draw is in range (best-case timing).
    while (r.align && !in_rng(lfsr_at(edge_cnt + 2)) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    eat_edge = edge_cnt;
    predict(eat_edge + 2, r.dly);
    bus.eat = 1'b1;
    grows = 0; cyc = 0; done = 1'b0; lat = 0;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (!r.hold_eat) bus.eat = 1'b0;
      if (bus.grow) grows++;
      respond();
      if (grows > 0 && !bus.grow && (bus.apple_valid || bus.fail)) begin
        done = 1'b1;
        lat  = edge_cnt - eat_edge;
      end
    end
    bus.eat = 1'b0;
    check({r.name, "_done"},     done, 1);
    check({r.name, "_grows"},    grows, 1);
    check({r.name, "_valid"},    bus.apple_valid, !r.exp_fail);
    check({r.name, "_fail"},     bus.fail, r.exp_fail);
    check({r.name, "_busy"},     bus.busy, 0);
    check({r.name, "_nreq"},     nreq, pred_nreq);
    check({r.name, "_left"},     exp_q.size(), 0);
    if (!r.exp_fail) begin
      check({r.name, "_apple_x"}, bus.apple_x, pred_x);
      check({r.name, "_apple_y"}, bus.apple_y, pred_y);
    end
    if (r.hand_x >= 0) begin
      check({r.name, "_hand_x"}, bus.apple_x, r.hand_x);
      check({r.name, "_hand_y"}, bus.apple_y, r.hand_y);
    end
    if (r.exp_lat > 0) check({r.name, "_latency"}, lat, r.exp_lat);
  endtask

  initial begin
    int g;
    bit seen;
    rows[0] = '{"free",     0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, -1, -1, 5};
    rows[1] = '{"hit3",     1, 3, 0, 0, 2, 1'b1, 1'b1, 1'b0, -1, -1, 0};
    rows[2] = '{"scan31",   2, 0, 3, 1, 0, 1'b0, 1'b0, 1'b0,  3,  1, 0};
    rows[3] = '{"full",     3, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, -1, -1, 0};

    bus.eat = 1'b0; bus.occ_ack = 1'b0; bus.occ_hit = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst_hold");
    rst = 1'b1;
    #1;
    check("lfsr_first", lfsr_o, SEED);
    check_reset("rst_rel");
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_row(rows[i]);

    // Board full: fail is sticky and eat no longer starts a placement.
    bus.eat = 1'b1;
    g = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.grow) g++;
    end
    bus.eat = 1'b0;
    check("fail_no_grow", g, 0);
    check("fail_sticky",  bus.fail, 1);
    check("fail_busy",    bus.busy, 0);
    check("fail_valid",   bus.apple_valid, 0);

    // Reset clears fail; then reset again in the middle of a query with a late ack afterwards.
    rst = 1'b0;
    #1;
    check_reset("rst_after_fail");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("lfsr_rerel", lfsr_o, SEED);
    @(negedge clk);
    bus.eat = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      bus.eat = 1'b0;
      if (bus.occ_req) seen = 1'b1;
    end
    check("midq_req_seen", seen, 1);
    rst = 1'b0;
    #1;
    check_reset("rst_midq");
    @(negedge clk);
    rst = 1'b1;
    bus.occ_ack = 1'b1;
    bus.occ_hit = 1'b0;
    @(negedge clk);
    bus.occ_ack = 1'b0;
    check_reset("late_ack");
    @(negedge clk);
    check("late_ack_state2", state_o, 0);
    check("late_ack_valid2", bus.apple_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
